// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch: owns the PC, drives instruction memory and
//            registers the returned word into IF/ID with stall/redirect/halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [9:0]  RESET_PC   = 10'h000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [9:0]  if_id_pc,
    output logic [9:0]  if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;

    localparam logic [9:0] c_pc_step  = 10'd4;
    localparam logic [9:0] c_reset_pc = {RESET_PC[9:2], 2'b00};

    logic [1:0]  r_state;
    logic [9:0]  r_pc;
    logic [31:0] r_instr;
    logic [9:0]  r_id_pc;
    logic [9:0]  r_id_pc4;
    logic        r_valid;
    logic        r_halted;
    logic        r_fault;

    logic [1:0]  w_state_nxt;
    logic [9:0]  w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [9:0]  w_id_pc_nxt;
    logic [9:0]  w_id_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_redirect_bad;

    assign w_redirect_bad = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_id_pc_nxt  = r_id_pc;
        w_id_pc4_nxt = r_id_pc4;
        w_valid_nxt  = r_valid;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_RUN;
            end
            S_RUN, S_HALTED: begin
                if (redirect) begin
                    // Any redirect squashes the in-flight fetch into a bubble.
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INSTR;
                    if (w_redirect_bad) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_pc_nxt    = redirect_pc;
                        w_state_nxt = S_RUN;
                    end
                end else if (stall) begin
                    w_state_nxt = r_state;
                end else if (r_state == S_HALTED) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INSTR;
                end else begin
                    w_instr_nxt  = imem_instr;
                    w_id_pc_nxt  = r_pc;
                    w_id_pc4_nxt = r_pc + c_pc_step;
                    w_valid_nxt  = 1'b1;
                    if (imem_instr == HALT_INSTR) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_pc_nxt = r_pc + c_pc_step;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= c_reset_pc;
            r_instr  <= NOP_INSTR;
            r_id_pc  <= 10'd0;
            r_id_pc4 <= 10'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_id_pc  <= w_id_pc_nxt;
            r_id_pc4 <= w_id_pc4_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= (w_state_nxt == S_HALTED);
            r_fault  <= (w_state_nxt == S_FAULT);
        end
    end

    assign imem_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_id_pc;
    assign if_id_pc_plus4 = r_id_pc4;
    assign if_id_valid    = r_valid;
    assign halted         = r_halted;
    assign fault          = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_halt = 32'hFFFF_FFFF;
    localparam logic [31:0] c_nop  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic [31:0] if_id_instr;
    logic [9:0]  if_id_pc;
    logic [9:0]  if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural view of the fetch unit.
    logic        m_started;
    logic        m_halted;
    logic        m_fault;
    int unsigned m_pc;
    logic [31:0] m_instr;
    int unsigned m_id_pc;
    int unsigned m_id_pc4;
    logic        m_valid;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fault          (fault)
    );

    assign imem_instr = mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",   {22'd0, imem_addr},      m_pc);
        chk("if_id_instr", if_id_instr,             m_instr);
        chk("if_id_pc",    {22'd0, if_id_pc},       m_id_pc);
        chk("if_id_pc4",   {22'd0, if_id_pc_plus4}, m_id_pc4);
        chk("if_id_valid", {31'd0, if_id_valid},    {31'd0, m_valid});
        chk("halted",      {31'd0, halted},         {31'd0, m_halted});
        chk("fault",       {31'd0, fault},          {31'd0, m_fault});
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_fault   = 1'b0;
        m_pc      = 0;
        m_instr   = c_nop;
        m_id_pc   = 0;
        m_id_pc4  = 0;
        m_valid   = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] word;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (redirect) begin
            m_valid = 1'b0;
            m_instr = c_nop;
            if (redirect_pc % 4 != 0) begin
                m_fault  = 1'b1;
                m_halted = 1'b0;
            end else begin
                m_pc     = redirect_pc;
                m_halted = 1'b0;
            end
        end else if (stall) begin
            // pure hold
        end else if (m_halted) begin
            m_valid = 1'b0;
            m_instr = c_nop;
        end else begin
            word     = mem[m_pc / 4];
            m_instr  = word;
            m_id_pc  = m_pc;
            m_id_pc4 = (m_pc + 4) % 1024;
            m_valid  = 1'b1;
            if (word == c_halt) m_halted = 1'b1;
            else m_pc = (m_pc + 4) % 1024;
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [9:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 10'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + (i << 12);
        mem[0] = 32'h0000_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_0193;
        mem[3] = c_halt;

        do_reset();
        step(0, 0, 0);           // idle settle
        step(0, 0, 0);           // pc 0x000 captured
        chk("first_pc", {22'd0, if_id_pc}, 32'h000);
        chk("first_instr", if_id_instr, 32'h0000_0093);
        step(0, 0, 0);           // 0x004
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("stall_addr", {22'd0, imem_addr}, 32'h008);
        step(0, 0, 0);           // 0x008
        step(0, 0, 0);           // 0x00C halt word
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("halt_addr", {22'd0, imem_addr}, 32'h00C);
        step(0, 1, 10'h020);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 1, 10'h100);     // redirect beats stall
        chk("redir_bubble", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0);
        chk("redir_target", {22'd0, if_id_pc}, 32'h100);
        step(0, 1, 10'h3F8);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(0, 1, 10'h022);     // misaligned
        for (int i = 0; i < 3; i++) step(i[0], 1, 10'h040);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Randomised phase with occasional halt words and periodic resets.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? c_halt : $urandom;
        for (int n = 0; n < 2000; n++) begin
            int unsigned roll;
            logic [9:0]  tgt;
            if (n % 250 == 249) do_reset();
            roll = $urandom_range(0, 99);
            tgt  = 10'($urandom_range(0, 1023));
            if (roll < 8) begin
                tgt[1:0] = 2'b00;
                step(1'($urandom_range(0, 1)), 1, tgt);
            end else if (roll < 9) begin
                tgt[0] = 1'b1;
                step(0, 1, tgt);
            end else begin
                step(roll < 30, 0, 10'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
